// File: rtl/v30mz_pkg.sv
// rtl/v30mz_pkg.sv - shared states, constants and magnitude helpers for the V30MZ divider
package v30mz_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX} div_state_e;

  localparam int DIV_BYTE_STEPS = 8;
  localparam int DIV_WORD_STEPS = 16;

  // Largest quotient magnitudes representable in the signed destination
  localparam logic [15:0] DIV_BYTE_POS_MAX = 16'h007F;
  localparam logic [15:0] DIV_BYTE_NEG_MAX = 16'h0080;
  localparam logic [15:0] DIV_WORD_POS_MAX = 16'h7FFF;
  localparam logic [15:0] DIV_WORD_NEG_MAX = 16'h8000;

  // Magnitude of an N-bit two's complement operand (N = 8 or 16)
  function automatic logic [15:0] abs_n(input logic size, input logic [15:0] x);
    logic [15:0] w;
    logic [7:0]  b;
    w = x[15] ? -x : x;
    b = x[7] ? -x[7:0] : x[7:0];
    return size ? w : {8'h00, b};
  endfunction

  // Magnitude of a 2N-bit two's complement dividend
  function automatic logic [31:0] abs_2n(input logic size, input logic [31:0] x);
    logic [31:0] w;
    logic [15:0] b;
    w = x[31] ? -x : x;
    b = x[15] ? -x[15:0] : x[15:0];
    return size ? w : {16'h0000, b};
  endfunction

  function automatic logic [15:0] neg_n(input logic size, input logic [15:0] x);
    logic [15:0] w;
    logic [7:0]  b;
    w = -x;
    b = -x[7:0];
    return size ? w : {8'h00, b};
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential restoring divider (DIVU/DIV), one quotient bit per cycle
module div_unit
  import v30mz_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        size,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  div_state_e  state, state_next;
  logic [4:0]  count;
  logic        size_q, signed_q, sign_a, sign_b, err_q, ovf_q;
  logic [15:0] r_q, q_q, d_q;

  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag, dvd_hi, dvd_lo;
  logic        div_zero, hi_ovf, early_err;

  logic [8:0]  rem9, diff9;
  logic [16:0] rem17, diff17;
  logic        bor;
  logic [15:0] r_next, q_next;

  logic        q_neg, sgn_ovf, fix_err;
  logic [15:0] pos_max, neg_max, q_res, r_res;

  // Operand conditioning at acceptance
  always_comb begin
    dvd_mag   = signed_op ? abs_2n(size, dividend)
                          : (size ? dividend : {16'h0000, dividend[15:0]});
    dvs_mag   = signed_op ? abs_n(size, divisor)
                          : (size ? divisor : {8'h00, divisor[7:0]});
    dvd_hi    = size ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
    dvd_lo    = size ? dvd_mag[15:0]  : {8'h00, dvd_mag[7:0]};
    div_zero  = (dvs_mag == 16'h0000);
    hi_ovf    = (dvd_hi >= dvs_mag);
    early_err = div_zero || (!signed_op && hi_ovf);
  end

  // One restoring step; the top bit of each difference is the borrow
  always_comb begin
    rem9   = {r_q[7:0], q_q[7]};
    diff9  = rem9 - {1'b0, d_q[7:0]};
    rem17  = {r_q, q_q[15]};
    diff17 = rem17 - {1'b0, d_q};
    if (size_q) begin
      bor    = diff17[16];
      r_next = bor ? {r_q[14:0], q_q[15]} : diff17[15:0];
      q_next = {q_q[14:0], ~bor};
    end else begin
      bor    = diff9[8];
      r_next = {8'h00, bor ? {r_q[6:0], q_q[7]} : diff9[7:0]};
      q_next = {8'h00, q_q[6:0], ~bor};
    end
  end

  // Sign fix-up and signed range check on the finished magnitudes
  always_comb begin
    q_neg   = sign_a ^ sign_b;
    pos_max = size_q ? DIV_WORD_POS_MAX : DIV_BYTE_POS_MAX;
    neg_max = size_q ? DIV_WORD_NEG_MAX : DIV_BYTE_NEG_MAX;
    sgn_ovf = signed_q && (ovf_q || (q_neg ? (q_q > neg_max) : (q_q > pos_max)));
    fix_err = err_q || sgn_ovf;
    q_res   = q_neg  ? neg_n(size_q, q_q) : q_q;
    r_res   = sign_a ? neg_n(size_q, r_q) : r_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= DIV_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = early_err ? DIV_FIX : DIV_RUN;
      DIV_RUN:  if (count == 5'd1) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 5'd0;
      size_q    <= 1'b0;
      signed_q  <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      r_q       <= 16'h0000;
      q_q       <= 16'h0000;
      d_q       <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_error <= 1'b0;
      quotient  <= 16'h0000;
      remainder <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            div_error <= 1'b0;
            size_q    <= size;
            signed_q  <= signed_op;
            sign_a    <= signed_op && (size ? dividend[31] : dividend[15]);
            sign_b    <= signed_op && (size ? divisor[15] : divisor[7]);
            err_q     <= early_err;
            // Signed magnitudes that overflow up front still walk RUN so the
            // error lands with the normal signed latency
            ovf_q     <= signed_op && hi_ovf;
            r_q       <= dvd_hi;
            q_q       <= dvd_lo;
            d_q       <= dvs_mag;
            count     <= size ? 5'(DIV_WORD_STEPS) : 5'(DIV_BYTE_STEPS);
          end
        end
        DIV_RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count - 5'd1;
        end
        DIV_FIX: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          div_error <= fix_err;
          if (!fix_err) begin
            quotient  <= q_res;
            remainder <= r_res;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential restoring divider for the V30MZ execution unit; executes DIVU/DIV, the inverse of the multiply path.
- The combinational ALU does not provide this operation.
- The sequencer starts it with a one-cycle pulse. It returns quotient, remainder and a divide-error indication (which raises INT 0).
- One quotient bit per cycle; byte divide is 16/8 bits, word divide is 32/16 bits.

Parameters:
- None. Widths are fixed by the V30MZ ISA.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- size  in  1  0 = byte (16/8 divide), 1 = word (32/16 divide).
- signed_op  in  1  0 = DIVU, 1 = DIV (two's complement).
- dividend  in  32  byte mode uses [15:0] and ignores [31:16].
- divisor  in  16  byte mode uses [7:0] and ignores [15:8].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- div_error  out  1  valid with done: divide by zero or quotient overflow.
- quotient  out  16  byte mode drives [15:8]=0.
- remainder  out  16  byte mode drives [15:8]=0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, busy=0, done=0, div_error=0, quotient=0, remainder=0, counter=0.
- Let N = 8 (byte) or 16 (word). Operands are latched on the edge where start is sampled in IDLE (edge 0).
- States:
  - IDLE: on start with divisor==0, go to FIX with the error flag set.
  - IDLE: on start with an unsigned early overflow, go to FIX with the error flag set. Early overflow means dividend high half >= divisor, with both operands taken as magnitudes when signed_op=0.
  - IDLE: otherwise go to RUN. Latch |dividend| and |divisor| (absolute values when signed_op=1), and latch both sign bits.
  - RUN: shift the partial remainder left by one. Trial-subtract the divisor; on no borrow, keep the difference and shift in quotient bit 1, else shift in 0. Decrement the counter. After N iterations go to FIX.
  - FIX: apply signs. Quotient is negated if the sign bits differ. Remainder takes the dividend's sign.
  - FIX: signed overflow check. A positive quotient magnitude above 0x7F/0x7FFF is an error. A negative quotient magnitude above 0x80/0x8000 is an error. An unsigned quotient that does not fit in N bits is an error.
  - FIX: register the outputs, pulse done, return to IDLE.
- Latency:
  - Normal path: done at edge N+2 (byte 10, word 18), with busy high for edges 1..N+1.
  - Early error path (divisor 0 or unsigned early overflow): done at edge 2.
- On error: div_error=1, and quotient/remainder hold their previous values (they are not updated).
- Outputs hold between operations. div_error is cleared at the next accepted start.
- start while busy: ignored, with no queueing.
- start in the same cycle done is high: accepted, since the state is IDLE.
- Asynchronous reset mid-operation: immediately IDLE, with all outputs at their reset values and no done pulse.
- The signed minimum results -128 (0x80) and -32768 (0x8000) are legal and do not set div_error.
- All arithmetic inside RUN is N+1 bits wide so the borrow is explicit; no $signed arithmetic is used in RUN.

Decomposition:
- Shared package v30mz_pkg:
  - enum DivState {DIV_IDLE, DIV_RUN, DIV_FIX}.
  - Constants DIV_BYTE_STEPS=8 and DIV_WORD_STEPS=16.
  - Overflow limits for the signed check.
  - Function abs_n(size, x) for the magnitude calculation.
- No sub-module: datapath and FSM live in one module, with magnitude and negate logic as package functions.

Test Plan:
- Unsigned word: size=1, signed_op=0, dividend 0x00010000, divisor 0x0003 -> quotient 0x5555, remainder 0x0001, div_error 0, done at edge 18.
- Unsigned byte: size=0, dividend 0x00FF, divisor 0x10 -> quotient 0x000F, remainder 0x000F, done at edge 10.
- Signed byte: dividend 0xFFF9 (-7), divisor 0x02 -> quotient 0x00FD (-3), remainder 0x00FF (-1), div_error 0.
- Signed byte boundary, legal case: dividend 0xFF80, divisor 0x01 -> quotient 0x0080, div_error 0.
- Signed byte boundary, error case: dividend 0x0080, divisor 0x01 -> div_error 1 at edge 10.
- Errors:
  - Word divide by zero -> div_error 1, done at edge 2, outputs unchanged.
  - Unsigned byte 0x0100/0x01 -> div_error 1 at edge 2.
- Control:
  - A second start during RUN is ignored, and exactly one done pulse is produced.
  - reset_n low at edge 5 of a word divide -> busy=0 immediately, no done pulse, outputs 0.
  - A new start in the done cycle completes normally.
